vdiv_seq: RTL and testbench
===========================

Name: vdiv_seq

Overview:
Vector-level sequencer directly upstream of the single-lane iterative FP divider (vdiv).
- Accepts one LANES-wide divide operation (dividend vector, divisor vector, lane mask).
- Issues the active lanes to the divider one at a time and collects each scalar quotient into a result vector.
- Presents the completed vector to writeback with a valid/ready handshake.

Parameters:
- LANES, 4, number of elements per vector operation.
- EXP_WIDTH, 8, FP exponent width; must match the divider.
- MANT_WIDTH, 7, FP mantissa width; must match the divider. Element width W = 1+EXP_WIDTH+MANT_WIDTH (16, bf16).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream vector op valid.
- in_ready  out  1  sequencer can accept a vector op.
- in_a  in  LANES*W  dividend vector; lane i at [i*W +: W].
- in_b  in  LANES*W  divisor vector, same packing.
- in_mask  in  LANES  1 = lane active.
- div_valid_in  out  1  operand pair valid to divider.
- div_ready_in  in  1  divider can accept operands.
- div_op1  out  W  dividend element.
- div_op2  out  W  divisor element.
- div_valid_out  in  1  divider result valid.
- div_ready_out  out  1  sequencer accepts divider result.
- div_result  in  W  divider quotient.
- out_valid  out  1  result vector valid.
- out_ready  in  1  downstream accepts result vector.
- out_result  out  LANES*W  quotient vector; masked lanes = 0.

Behaviour:
- Reset (async, nRST=0):
  - state=IDLE; all outputs 0 except in_ready=1.
  - Internal operand, mask and result registers cleared.
  - Reset mid-operation abandons the op with no output. The divider shares nRST and is reset in the same event.
- State machine IDLE / ISSUE / WAIT / DONE:
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready: latch in_a, in_b and in_mask into pending mask; clear result register; go to ISSUE.
  - ISSUE:
    - idx = lowest set bit of the pending mask.
    - If the pending mask is 0, go to DONE without asserting div_valid_in.
    - Otherwise drive div_valid_in=1 with div_op1/div_op2 = lane idx operands.
    - On div_valid_in&&div_ready_in, clear pending bit idx, hold idx in a register, go to WAIT.
    - Operands stay stable until accepted. div_ready_in may be 0 for the first cycles after reset; keep waiting.
  - WAIT:
    - div_ready_out=1.
    - On div_valid_out, write div_result to lane idx of the result register, then go to ISSUE.
  - DONE:
    - out_valid=1, out_result = result register.
    - On out_ready, go to IDLE. in_ready rises the next cycle; there is no same-cycle re-accept.
- Handshake rules:
  - At most one element is outstanding in the divider.
  - div_ready_out is asserted only in WAIT.
  - div_valid_in is asserted only in ISSUE with a nonzero pending mask.
  - out_valid, once asserted, holds with out_result stable until out_ready.
- Latency per vector, with k = active lanes and D = divider latency (D=0 for special-case skip):
  - 1 accept cycle;
  - k*(1 + D + 1) cycles plus any div_ready_in stall;
  - 1 cycle to DONE.
  - With k=0: IDLE→ISSUE→DONE, so out_valid rises 2 cycles after accept.
- Lane order is strictly ascending index.
- Masked lanes are never sent to the divider; their output is 0.
- No arithmetic is performed here. Results are copied bit-exact from the divider; signs, NaN, inf and zero are produced entirely by the divider.
- Simultaneous events:
  - in_valid while not IDLE is ignored (in_ready=0).
  - div_valid_out outside WAIT is left unacknowledged; it cannot occur in correct operation, and the bench flags it.

Decomposition:
- Package vdiv_seq_pkg:
  - state enum (IDLE, ISSUE, WAIT, DONE);
  - localparams W and IDX_W = $clog2(LANES);
  - element typedef logic [W-1:0].
- Sub-module vdiv_lane_sel: combinational lowest-set-bit priority encoder over LANES bits, outputs idx and any.
- Top-level instance pairs vdiv_seq with vdiv through vdiv_if.

Test Plan:
1. Full mask, LANES=4 bf16:
   - Stimulus: a = {0x40C0, 0x3F80, 0x4000, 0x3F80}, b = {0x4040, 0x4000, 0x3F80, 0x3F80}.
   - Required: out_result = {0x4000, 0x3F00, 0x4000, 0x3F80}; exactly 4 divider handshakes, in lane order 0,1,2,3.
2. Mask 0b0101:
   - Required: only lanes 0 and 2 are issued; lanes 1 and 3 of out_result = 0x0000.
3. Mask 0b0000:
   - Required: no div_valid_in ever; out_valid rises 2 cycles after accept; out_result = 0.
4. Special values:
   - Stimulus: lane 0 = 0x3F80/0x0000, lane 1 = 0x0000/0x0000, lane 2 = 0x7F80/0x3F80.
   - Required: 0x7F80, 0xFFC0 or 0x7FC0 (sign per divider), 0x7F80; divider skip path completes each in 1 cycle.
5. Backpressure: hold out_ready=0 for 10 cycles in DONE.
   - Required: out_valid and out_result stable; in_ready=0 throughout; in_ready=1 the cycle after out_ready.
6. Reset mid-operation: assert nRST=0 while in WAIT.
   - Required: the same cycle, div_valid_in=0 and out_valid=0; in_ready=1 after release. The next vector completes correctly.

Source files
------------

// File: rtl/vdiv_seq_pkg.sv
// Shared types for the vector divide sequencer.
// Element width and lane index width derive from the bf16 defaults.
package vdiv_seq_pkg;

  localparam int LANES_DEF = 4;
  localparam int EXP_DEF   = 8;
  localparam int MANT_DEF  = 7;
  localparam int W         = 1 + EXP_DEF + MANT_DEF;
  localparam int IDX_W     = $clog2(LANES_DEF);

  typedef logic [W-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/vdiv_lane_sel.sv
// Lowest-set-bit priority encoder picking the next lane to issue.
// Scanning from the top lets the lowest request win last.
module vdiv_lane_sel #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = IW'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vdiv_seq.sv
// Feeds active lanes of a vector divide to a scalar divider one at a time
// and returns the gathered quotient vector over a valid/ready handshake.
module vdiv_seq
  import vdiv_seq_pkg::*;
#(
  parameter int LANES      = LANES_DEF,
  parameter int EXP_WIDTH  = EXP_DEF,
  parameter int MANT_WIDTH = MANT_DEF
) (
  input  logic                            CLK,
  input  logic                            nRST,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES*(1+EXP_WIDTH+MANT_WIDTH)-1:0] in_a,
  input  logic [LANES*(1+EXP_WIDTH+MANT_WIDTH)-1:0] in_b,
  input  logic [LANES-1:0]                in_mask,
  output logic                            div_valid_in,
  input  logic                            div_ready_in,
  output logic [EXP_WIDTH+MANT_WIDTH:0]   div_op1,
  output logic [EXP_WIDTH+MANT_WIDTH:0]   div_op2,
  input  logic                            div_valid_out,
  output logic                            div_ready_out,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]   div_result,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES*(1+EXP_WIDTH+MANT_WIDTH)-1:0] out_result
);

  localparam int EW = 1 + EXP_WIDTH + MANT_WIDTH;
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  state_t               r_state;
  state_t               w_next;
  logic [LANES*EW-1:0]  r_a;
  logic [LANES*EW-1:0]  r_b;
  logic [LANES*EW-1:0]  r_res;
  logic [LANES-1:0]     r_pend;
  logic [IW-1:0]        r_idx;
  logic [IW-1:0]        w_idx;
  logic                 w_any;
  logic                 w_acc;
  logic                 w_iss;
  logic                 w_ret;
  logic                 w_fin;

  vdiv_lane_sel #(
    .N  (LANES),
    .IW (IW)
  ) u_sel (
    .i_req (r_pend),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_acc = (r_state == IDLE) && in_valid;
  assign w_iss = (r_state == ISSUE) && w_any && div_ready_in;
  assign w_ret = (r_state == WAIT) && div_valid_out;
  assign w_fin = (r_state == DONE) && out_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_acc) w_next = ISSUE;
      ISSUE: begin
        if (!w_any)     w_next = DONE;
        else if (w_iss) w_next = WAIT;
      end
      WAIT:  if (w_ret) w_next = ISSUE;
      DONE:  if (w_fin) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready      = 1'b0;
    div_valid_in  = 1'b0;
    div_op1       = '0;
    div_op2       = '0;
    div_ready_out = 1'b0;
    out_valid     = 1'b0;
    out_result    = '0;
    unique case (r_state)
      IDLE:  in_ready = 1'b1;
      ISSUE: begin
        div_valid_in = w_any;
        if (w_any) begin
          div_op1 = r_a[w_idx*EW +: EW];
          div_op2 = r_b[w_idx*EW +: EW];
        end
      end
      WAIT:  div_ready_out = 1'b1;
      DONE: begin
        out_valid  = 1'b1;
        out_result = r_res;
      end
      default: ;
    endcase
  end

  // Operand, pending-mask and result storage; r_idx remembers the lane in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_pend <= '0;
      r_idx  <= '0;
    end else begin
      if (w_acc) begin
        r_a    <= in_a;
        r_b    <= in_b;
        r_pend <= in_mask;
        r_res  <= '0;
      end
      if (w_iss) begin
        r_pend[w_idx] <= 1'b0;
        r_idx         <= w_idx;
      end
      if (w_ret) r_res[r_idx*EW +: EW] <= div_result;
    end
  end

endmodule

// File: tb/tb_vdiv_seq.sv
// Bench for vdiv_seq: behavioural divider, lane-order scoreboard and
// directed vectors with hand-computed quotients.
module tb_vdiv_seq;

  localparam logic [63:0] A1 = 64'h40C0_3F80_4000_3F80;
  localparam logic [63:0] B1 = 64'h4040_4000_3F80_3F80;
  localparam logic [63:0] AS = 64'h0000_7F80_0000_3F80;
  localparam logic [63:0] BS = 64'h0000_3F80_0000_0000;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [3:0]  in_mask;
  logic        div_valid_in;
  logic        div_ready_in;
  logic [15:0] div_op1;
  logic [15:0] div_op2;
  logic        div_valid_out;
  logic        div_ready_out;
  logic [15:0] div_result;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;

  int n_pass = 0;
  int n_tot  = 0;
  int n_issue = 0;
  int r_lat  = 2;

  always #5 CLK = ~CLK;

  vdiv_seq dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_mask       (in_mask),
    .div_valid_in  (div_valid_in),
    .div_ready_in  (div_ready_in),
    .div_op1       (div_op1),
    .div_op2       (div_op2),
    .div_valid_out (div_valid_out),
    .div_ready_out (div_ready_out),
    .div_result    (div_result),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [15:0] divq(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3F80_3F80: return 16'h3F80;
      32'h4000_3F80: return 16'h4000;
      32'h3F80_4000: return 16'h3F00;
      32'h40C0_4040: return 16'h4000;
      32'h3F80_0000: return 16'h7F80;
      32'h0000_0000: return 16'h7FC0;
      32'h7F80_3F80: return 16'h7F80;
      default:       return a ^ b ^ 16'h5A5A;
    endcase
  endfunction

  function automatic bit special(input logic [15:0] a, input logic [15:0] b);
    return (a[14:0] == 0) || (b[14:0] == 0) ||
           (a[14:7] == 8'hFF) || (b[14:7] == 8'hFF);
  endfunction

  function automatic logic [63:0] exp_vec(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [3:0] m);
    logic [63:0] v = '0;
    for (int i = 0; i < 4; i++)
      if (m[i]) v[i*16 +: 16] = divq(a[i*16 +: 16], b[i*16 +: 16]);
    return v;
  endfunction

  // Scalar divider stand-in: one operand at a time, fixed or zero latency.
  initial begin : divider
    bit          s_hin, s_hout, rbusy;
    int          rcnt, rstall;
    logic [15:0] s_a, s_b;
    div_ready_in  = 1'b0;
    div_valid_out = 1'b0;
    div_result    = '0;
    rbusy  = 0;
    rstall = 3;
    rcnt   = 0;
    forever begin
      @(negedge CLK);
      s_hin  = nRST && div_valid_in && div_ready_in;
      s_hout = nRST && div_valid_out && div_ready_out;
      s_a    = div_op1;
      s_b    = div_op2;
      if (!nRST) begin
        rbusy = 0;
        div_valid_out = 1'b0;
        div_ready_in  = 1'b0;
        rstall = 3;
        continue;
      end
      @(posedge CLK);
      #1;
      if (!nRST) continue;
      if (s_hout) begin
        div_valid_out = 1'b0;
        rbusy = 0;
      end else if (rbusy && !div_valid_out) begin
        rcnt--;
        if (rcnt <= 0) div_valid_out = 1'b1;
      end
      if (s_hin) begin
        rbusy = 1;
        div_ready_in = 1'b0;
        div_result = divq(s_a, s_b);
        rcnt = special(s_a, s_b) ? 0 : r_lat;
        if (rcnt == 0) div_valid_out = 1'b1;
      end else if (!rbusy) begin
        if (rstall > 0) begin
          rstall--;
          div_ready_in = 1'b0;
        end else begin
          div_ready_in = 1'b1;
        end
      end
    end
  end

  // Scoreboard: lane order, operands, result vector and handshake rules.
  initial begin : scoreboard
    bit          active = 0;
    int          lane_q[$];
    int          ln;
    logic [63:0] m_a, m_b, m_vec;
    m_a = '0; m_b = '0; m_vec = '0;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        active = 0;
        lane_q.delete();
        continue;
      end
      chk("in_ready", in_ready, !active);
      if (in_valid && in_ready) begin
        m_a = in_a;
        m_b = in_b;
        m_vec = exp_vec(in_a, in_b, in_mask);
        lane_q.delete();
        for (int i = 0; i < 4; i++) if (in_mask[i]) lane_q.push_back(i);
        active = 1;
      end
      if (div_valid_in && div_ready_in) begin
        if (lane_q.size() == 0) begin
          chk("spurious_issue", 1, 0);
        end else begin
          ln = lane_q.pop_front();
          chk("op1", div_op1, m_a[ln*16 +: 16]);
          chk("op2", div_op2, m_b[ln*16 +: 16]);
          n_issue++;
        end
      end
      if (div_valid_out) chk("ret_outside_wait", div_ready_out, 1);
      if (out_valid) begin
        chk("out_result", out_result, m_vec);
        if (out_ready) begin
          chk("all_issued", lane_q.size(), 0);
          active = 0;
        end
      end
    end
  end

  task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] m, input int hold,
                       output logic [63:0] res, output int lat);
    int t;
    n_issue = 0;
    res = '0;
    @(posedge CLK);
    #1;
    in_a = a;
    in_b = b;
    in_mask = m;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    t = 0;
    @(negedge CLK);
    while (!in_ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!out_valid && lat < 300);
    if (!out_valid) begin
      chk("done_timeout", 0, 1);
      return;
    end
    res = out_result;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        chk("bp_valid", out_valid, 1);
        chk("bp_stable", out_result, res);
        chk("bp_in_ready", in_ready, 0);
        @(negedge CLK);
      end
      @(posedge CLK);
      #1;
      out_ready = 1'b1;
      @(negedge CLK);
    end
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    @(negedge CLK);
    chk("in_ready_after_out", in_ready, 1);
  endtask

  initial begin : main
    logic [63:0] res;
    int          lat, t;
    nRST = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_mask = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_ctl", {in_ready, div_valid_in, div_ready_out, out_valid}, 4'b1000);
    chk("rst_out", out_result, 0);
    chk("rst_ops", {div_op1, div_op2}, 0);
    repeat (2) @(posedge CLK);
    #3 nRST = 1'b1;
    repeat (5) @(posedge CLK);

    do_op(A1, B1, 4'hF, 0, res, lat);
    chk("t1_res", res, 64'h4000_3F00_4000_3F80);
    chk("t1_issues", n_issue, 4);
    chk("t1_lat", lat, 18);

    do_op(A1, B1, 4'b0101, 0, res, lat);
    chk("t2_res", res, 64'h0000_3F00_0000_3F80);
    chk("t2_issues", n_issue, 2);
    chk("t2_lat", lat, 10);

    do_op(A1, B1, 4'b0000, 0, res, lat);
    chk("t3_res", res, 0);
    chk("t3_issues", n_issue, 0);
    chk("t3_lat", lat, 2);

    do_op(AS, BS, 4'b0111, 0, res, lat);
    chk("t4_res", res, 64'h0000_7F80_7FC0_7F80);
    chk("t4_issues", n_issue, 3);
    chk("t4_lat", lat, 8);

    do_op(A1, B1, 4'hF, 10, res, lat);
    chk("t5_res", res, 64'h4000_3F00_4000_3F80);

    @(posedge CLK);
    #1;
    in_a = A1;
    in_b = B1;
    in_mask = 4'hF;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge CLK);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (!div_ready_out && t < 50);
    chk("t6_reach_wait", div_ready_out, 1);
    @(posedge CLK);
    #3;
    nRST = 1'b0;
    div_valid_out = 1'b0;
    #1;
    chk("t6_rst_div_valid", div_valid_in, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    repeat (2) @(posedge CLK);
    #3 nRST = 1'b1;
    #1;
    chk("t6_in_ready", in_ready, 1);
    repeat (6) @(posedge CLK);
    do_op(A1, B1, 4'hF, 0, res, lat);
    chk("t6_res", res, 64'h4000_3F00_4000_3F80);
    chk("t6_issues", n_issue, 4);

    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
